// File: rtl/pong_relay_stage.sv
// Middle relay board of the chained pong track: accepts the ball from either link,
// walks it across POS_MAX+1 lamps, and hands it to the far side. Optional macro: LINK_SYNC_EN.
module pong_relay_stage #(
  parameter int POS_MAX  = 7,
  parameter int BASE_DIV = 1000,
  parameter int SCAN_DIV = 250
) (
  input  logic       clk,
  input  logic       resetbutton,
  input  logic [4:0] from_left,
  input  logic [4:0] from_right,
  output logic [4:0] to_left,
  output logic [4:0] to_right,
  output logic [2:0] pos_c,
  output logic [2:0] sel,
  output logic       lit,
  output logic       drop
);

  localparam int CW = $clog2(16*BASE_DIV+1);
  localparam int SW = $clog2(SCAN_DIV+1);
  localparam logic [2:0] PMAX = 3'(POS_MAX);

  typedef enum logic [2:0] {IDLE, RUN_R, RUN_L, HAND_R, HAND_L} state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_pos, r_sel;
  logic [3:0]      r_speed, w_spd_out;
  logic [CW-1:0]   r_cnt, w_period_m1;
  logic [SW-1:0]   r_presc;
  logic            r_lit, r_drop;
  logic [4:0]      w_left, w_right;
  logic            w_lv, w_rv, w_wrap, w_owned;

`ifdef LINK_SYNC_EN
  // Neighbour may run on its own clock: two flops per link bit before use.
  logic [4:0] r_l_s1, r_l_s2, r_r_s1, r_r_s2;
  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) begin
      r_l_s1 <= '0; r_l_s2 <= '0;
      r_r_s1 <= '0; r_r_s2 <= '0;
    end else begin
      r_l_s1 <= from_left;  r_l_s2 <= r_l_s1;
      r_r_s1 <= from_right; r_r_s2 <= r_r_s1;
    end
  end
  assign w_left  = r_l_s2;
  assign w_right = r_r_s2;
`else
  assign w_left  = from_left;
  assign w_right = from_right;
`endif

  assign w_lv        = w_left[4];
  assign w_rv        = w_right[4];
  assign w_period_m1 = CW'(BASE_DIV * (16 - int'(r_speed)) - 1);
  assign w_wrap      = (r_cnt == w_period_m1);
  assign w_spd_out   = (r_speed == 4'd15) ? 4'd15 : r_speed + 4'd1;
  assign w_owned     = (r_state != IDLE);

  // State register
  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) r_state <= IDLE;
    else              r_state <= w_next;
  end

  // Next-state logic; left wins a same-cycle tie
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_lv) w_next = RUN_R;
              else if (w_rv) w_next = RUN_L;
      RUN_R:  if (w_wrap && r_pos == PMAX) w_next = HAND_R;
      RUN_L:  if (w_wrap && r_pos == 3'd0) w_next = HAND_L;
      HAND_R: w_next = IDLE;
      HAND_L: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    to_left  = 5'b0;
    to_right = 5'b0;
    if (r_state == HAND_R) to_right = {1'b1, w_spd_out};
    if (r_state == HAND_L) to_left  = {1'b1, w_spd_out};
  end

  // Ball datapath: position, latched speed, move counter
  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) begin
      r_pos   <= '0;
      r_speed <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_lv) begin
            r_pos   <= 3'd0;
            r_speed <= w_left[3:0];
          end else if (w_rv) begin
            r_pos   <= PMAX;
            r_speed <= w_right[3:0];
          end
        end
        RUN_R: begin
          if (w_wrap) begin
            r_cnt <= '0;
            if (r_pos != PMAX) r_pos <= r_pos + 3'd1;
          end else r_cnt <= r_cnt + CW'(1);
        end
        RUN_L: begin
          if (w_wrap) begin
            r_cnt <= '0;
            if (r_pos != 3'd0) r_pos <= r_pos - 3'd1;
          end else r_cnt <= r_cnt + CW'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Display scan and lamp/drop flags
  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) begin
      r_presc <= '0;
      r_sel   <= '0;
      r_lit   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (r_presc == SW'(SCAN_DIV-1)) begin
        r_presc <= '0;
        r_sel   <= (r_sel == PMAX) ? 3'd0 : r_sel + 3'd1;
      end else r_presc <= r_presc + SW'(1);
      r_lit  <= w_owned && (r_sel == r_pos);
      r_drop <= w_owned ? (w_lv || w_rv) : (w_lv && w_rv);
    end
  end

  assign pos_c = r_pos;
  assign sel   = r_sel;
  assign lit   = r_lit;
  assign drop  = r_drop;

endmodule

// File: tb/tb_pong_relay_stage.sv
// Directed bench for pong_relay_stage with BASE_DIV=4, SCAN_DIV=250.
module tb_pong_relay_stage;
`ifdef LINK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk, resetbutton;
  logic [4:0] from_left, from_right, to_left, to_right;
  logic [2:0] pos_c, sel;
  logic       lit, drop;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  pong_relay_stage #(.POS_MAX(7), .BASE_DIV(4), .SCAN_DIV(250)) dut (
    .clk(clk), .resetbutton(resetbutton),
    .from_left(from_left), .from_right(from_right),
    .to_left(to_left), .to_right(to_right),
    .pos_c(pos_c), .sel(sel), .lit(lit), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic go(input int n);
    if (n > cyc) step(n - cyc);
  endtask

  // Reset released just after an edge; the next edge is cycle 1.
  task automatic do_reset();
    from_left = '0; from_right = '0;
    resetbutton = 1'b0;
    @(posedge clk); #1;
    resetbutton = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    resetbutton = 1'b0; from_left = '0; from_right = '0;
    #2;
    check("rst_to_left", to_left, 0);
    check("rst_to_right", to_right, 0);
    check("rst_pos", pos_c, 0);
    check("rst_sel", sel, 0);
    check("rst_lit", lit, 0);
    check("rst_drop", drop, 0);

    // 1: idle, scan timing
    do_reset();
    go(100);
    check("t1_to_left", to_left, 0);
    check("t1_to_right", to_right, 0);
    check("t1_lit", lit, 0);
    go(249);  check("t1_sel249", sel, 0);
    go(250);  check("t1_sel250", sel, 1);
    go(500);  check("t1_sel500", sel, 2);
    go(1999); check("t1_sel1999", sel, 7);
    go(2000); check("t1_selwrap", sel, 0);

    // 2: left entry at speed 0, 64 cycles per lamp
    do_reset();
    from_left = 5'b1_0000;
    step(1);
    from_left = '0;
    go(1 + LAT);   check("t2_pos_start", pos_c, 0); check("t2_drop", drop, 0);
    go(10);        check("t2_lit_on", lit, 1);
    go(64 + LAT);  check("t2_pos0_end", pos_c, 0);
    go(65 + LAT);  check("t2_pos1", pos_c, 1);
    go(100);       check("t2_lit_off", lit, 0);
    go(449 + LAT); check("t2_pos7", pos_c, 7);
    go(512 + LAT); check("t2_pos7_end", pos_c, 7); check("t2_no_early", to_right, 0);
    go(513 + LAT); check("t2_hand", to_right, 5'h11); check("t2_hand_l", to_left, 0);
    go(514 + LAT); check("t2_hand_off", to_right, 0); check("t2_idle_lit", lit, 0);
    go(540 + LAT); check("t2_quiet", to_right, 0); check("t2_pos_hold", pos_c, 7);

    // 3: right entry at speed 15, saturating handoff
    do_reset();
    from_right = 5'b1_1111;
    step(1);
    from_right = '0;
    go(1 + LAT);  check("t3_pos_start", pos_c, 7);
    go(4 + LAT);  check("t3_pos7_end", pos_c, 7);
    go(5 + LAT);  check("t3_pos6", pos_c, 6);
    go(29 + LAT); check("t3_pos0", pos_c, 0);
    go(32 + LAT); check("t3_pos0_end", pos_c, 0); check("t3_no_early", to_left, 0);
    go(33 + LAT); check("t3_hand", to_left, 5'h1F); check("t3_hand_r", to_right, 0);
    go(34 + LAT); check("t3_hand_off", to_left, 0);

    // 4: tie in IDLE, left wins
    do_reset();
    from_left = 5'b1_0000; from_right = 5'b1_1111;
    step(1);
    from_left = '0; from_right = '0;
    go(1 + LAT);  check("t4_drop", drop, 1); check("t4_pos", pos_c, 0);
    go(2 + LAT);  check("t4_drop_off", drop, 0);
    go(65 + LAT); check("t4_dir_r", pos_c, 1);

    // 5: stray right valid during RUN_R
    go(99);
    from_right = 5'b1_0011;
    step(1);
    from_right = '0;
    go(100 + LAT); check("t5_drop", drop, 1);
    go(101 + LAT); check("t5_drop_off", drop, 0);
    go(128 + LAT); check("t5_pos1", pos_c, 1);
    go(129 + LAT); check("t5_pos2", pos_c, 2);

    // 6: reset mid-run at lamp 3
    do_reset();
    from_left = 5'b1_0000;
    step(1);
    from_left = '0;
    go(200 + LAT); check("t6_pos3", pos_c, 3);
    resetbutton = 1'b0;
    #2;
    check("t6_rst_pos", pos_c, 0);
    check("t6_rst_lit", lit, 0);
    check("t6_rst_sel", sel, 0);
    @(posedge clk); #1;
    resetbutton = 1'b1;
    cyc = 0;
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (to_right != 0 || to_left != 0 || pos_c != 0) seen++;
    end
    check("t6_no_hand", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
